// File: rtl/lp_filter_pkg.sv
// Shared helpers for the multi-channel low-pass filter.
//   sw()         : width of one stage's state (integer sample bits + fractional bits)
//   clog2_min1() : channel-index width, never narrower than one bit
package lp_filter_pkg;

    function automatic int sw(input int data_bits, input int frac_bits);
        return data_bits + frac_bits;
    endfunction

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lp_filter_mc_if.sv
// Sample/result bus of lp_filter_mc.
//   in_valid/in_channel/in_value/in_prime/shift : producer -> filter
//   out_valid/out_channel/out_value             : filter -> consumer
// slave = filter side, master = producer/consumer side.
interface lp_filter_mc_if #(
    parameter int DATA_BITS = 28,
    parameter int CH_W      = 2,
    parameter int SHIFT_W   = 4
);
    logic                 in_valid;
    logic [CH_W-1:0]      in_channel;
    logic [DATA_BITS-1:0] in_value;
    logic                 in_prime;
    logic [SHIFT_W-1:0]   shift;
    logic                 out_valid;
    logic [CH_W-1:0]      out_channel;
    logic [DATA_BITS-1:0] out_value;

    modport master (
        output in_valid, in_channel, in_value, in_prime, shift,
        input  out_valid, out_channel, out_value
    );

    modport slave (
        input  in_valid, in_channel, in_value, in_prime, shift,
        output out_valid, out_channel, out_value
    );
endinterface

// File: rtl/lp_filter_mc_stage.sv
// One exponential low-pass stage shared by all channels.
// Ports:
//   clk, reset_n, ce           : clock, async active-low reset, clock enable
//   in_valid/channel/shift/prime : tag of the sample entering this stage
//   in_x                       : stage input, full state width (x << FRAC_BITS for stage 0)
//   out_*                      : same tag one cycle later, out_x = updated state
// Per-channel state is a register array read combinationally, so a write is seen
// by the very next sample of the same channel without any forwarding.
module lp_filter_mc_stage
    import lp_filter_pkg::*;
#(
    parameter int DATA_BITS = 28,
    parameter int CHANNELS  = 4,
    parameter int FRAC_BITS = 8,
    parameter int SHIFT_W   = 4,
    parameter int CH_W      = 2
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   ce,
    input  logic                                   in_valid,
    input  logic [CH_W-1:0]                        in_channel,
    input  logic [SHIFT_W-1:0]                     in_shift,
    input  logic                                   in_prime,
    input  logic [sw(DATA_BITS, FRAC_BITS)-1:0]    in_x,
    output logic                                   out_valid,
    output logic [CH_W-1:0]                        out_channel,
    output logic [SHIFT_W-1:0]                     out_shift,
    output logic                                   out_prime,
    output logic [sw(DATA_BITS, FRAC_BITS)-1:0]    out_x
);
    localparam int SW = sw(DATA_BITS, FRAC_BITS);

    logic [SW-1:0]        state_reg [CHANNELS];
    logic [SW-1:0]        y_cur;
    logic [SW-1:0]        y_next;
    logic signed [SW:0]   diff;
    logic signed [SW:0]   delta;

    always_comb begin
        y_cur = state_reg[in_channel];
        diff  = $signed({1'b0, in_x}) - $signed({1'b0, y_cur});
        delta = diff >>> in_shift;
        // Shifting the whole difference away leaves 0 or -1; hold the state instead.
        if (32'(in_shift) > SW) begin
            delta = '0;
        end
        // Result always lies between y and x, so dropping the top bit is lossless.
        if (in_prime) begin
            y_next = in_x;
        end else begin
            y_next = SW'({1'b0, y_cur} + delta);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_reg[i] <= '0;
            end
            out_valid   <= 1'b0;
            out_channel <= '0;
            out_shift   <= '0;
            out_prime   <= 1'b0;
            out_x       <= '0;
        end else if (ce) begin
            if (in_valid) begin
                state_reg[in_channel] <= y_next;
            end
            out_valid   <= in_valid;
            out_channel <= in_channel;
            out_shift   <= in_shift;
            out_prime   <= in_prime;
            out_x       <= y_next;
        end
    end
endmodule

// File: rtl/lp_filter_mc.sv
// Multi-channel, time-multiplexed cascade of exponential low-pass stages
// (y += (x - y) >>> shift per stage) with fractional state, first-sample
// priming and valid-tagged, rounded and saturated output.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   ce           : clock enable, low freezes every register
//   bus          : lp_filter_mc_if.slave sample in / filtered result out
// Latency from acceptance to out_valid is STAGE_COUNT+1 enabled cycles.
module lp_filter_mc
    import lp_filter_pkg::*;
#(
    parameter int DATA_BITS   = 28,
    parameter int CHANNELS    = 4,
    parameter int STAGE_COUNT = 2,
    parameter int FRAC_BITS   = 8,
    parameter int SHIFT_W     = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ce,
    lp_filter_mc_if.slave bus
);
    localparam int CH_W = clog2_min1(CHANNELS);
    localparam int SW   = sw(DATA_BITS, FRAC_BITS);
    localparam logic [SW:0] RND = (SW+1)'((64'd1 << FRAC_BITS) >> 1);

    typedef struct packed {
        logic               valid;
        logic [CH_W-1:0]    channel;
        logic [SHIFT_W-1:0] shift;
        logic               prime;
    } tag_t;

    logic [CHANNELS-1:0]  primed_reg;
    logic                 accept;
    tag_t                 in_tag;

    logic                 valid_pipe   [STAGE_COUNT+1];
    logic [CH_W-1:0]      channel_pipe [STAGE_COUNT+1];
    logic [SHIFT_W-1:0]   shift_pipe   [STAGE_COUNT+1];
    logic                 prime_pipe   [STAGE_COUNT+1];
    logic [SW-1:0]        x_pipe       [STAGE_COUNT+1];

    logic [DATA_BITS:0]   rounded;
    logic [DATA_BITS-1:0] out_value_next;
    logic                 out_valid_reg;
    logic [CH_W-1:0]      out_channel_reg;
    logic [DATA_BITS-1:0] out_value_reg;

    // Out-of-range channels are never accepted; they become a bubble and the
    // channel field is forced to 0 so no state array is indexed out of bounds.
    assign accept = ce & bus.in_valid & (32'(bus.in_channel) < CHANNELS);

    always_comb begin
        in_tag.valid   = accept;
        in_tag.channel = accept ? bus.in_channel : '0;
        in_tag.shift   = bus.shift;
        in_tag.prime   = bus.in_prime | ~primed_reg[in_tag.channel];
    end

    assign valid_pipe[0]   = in_tag.valid;
    assign channel_pipe[0] = in_tag.channel;
    assign shift_pipe[0]   = in_tag.shift;
    assign prime_pipe[0]   = in_tag.prime;
    assign x_pipe[0]       = {bus.in_value, {FRAC_BITS{1'b0}}};

    generate
        for (genvar gi = 0; gi < STAGE_COUNT; gi++) begin : g_stage
            lp_filter_mc_stage #(
                .DATA_BITS (DATA_BITS),
                .CHANNELS  (CHANNELS),
                .FRAC_BITS (FRAC_BITS),
                .SHIFT_W   (SHIFT_W),
                .CH_W      (CH_W)
            ) u_stage (
                .clk         (clk),
                .reset_n     (reset_n),
                .ce          (ce),
                .in_valid    (valid_pipe[gi]),
                .in_channel  (channel_pipe[gi]),
                .in_shift    (shift_pipe[gi]),
                .in_prime    (prime_pipe[gi]),
                .in_x        (x_pipe[gi]),
                .out_valid   (valid_pipe[gi+1]),
                .out_channel (channel_pipe[gi+1]),
                .out_shift   (shift_pipe[gi+1]),
                .out_prime   (prime_pipe[gi+1]),
                .out_x       (x_pipe[gi+1])
            );
        end
    endgenerate

    // Round half up, then clamp: the top state values round to 2^DATA_BITS.
    assign rounded        = (DATA_BITS+1)'(({1'b0, x_pipe[STAGE_COUNT]} + RND) >> FRAC_BITS);
    assign out_value_next = rounded[DATA_BITS] ? '1 : rounded[DATA_BITS-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            primed_reg      <= '0;
            out_valid_reg   <= 1'b0;
            out_channel_reg <= '0;
            out_value_reg   <= '0;
        end else if (ce) begin
            if (accept) begin
                primed_reg[in_tag.channel] <= 1'b1;
            end
            out_valid_reg <= valid_pipe[STAGE_COUNT];
            if (valid_pipe[STAGE_COUNT]) begin
                out_channel_reg <= channel_pipe[STAGE_COUNT];
                out_value_reg   <= out_value_next;
            end
        end
    end

    assign bus.out_valid   = out_valid_reg;
    assign bus.out_channel = out_channel_reg;
    assign bus.out_value   = out_value_reg;
endmodule

// File: tb/tb_lp_filter_mc.sv
// Directed bench for lp_filter_mc (28-bit data, 4 channels, 2 stages, 8 frac bits)
// plus a second instance (3 channels, 0 stages) for pass-through and dropped channels.
module tb_lp_filter_mc;
    localparam int  DB  = 28;
    localparam int  CH  = 4;
    localparam int  SC  = 2;
    localparam int  FB  = 8;
    localparam int  SHW = 4;
    localparam int  CHW = 2;
    localparam int  SW  = DB + FB;
    localparam int  LAT = SC + 1;
    localparam longint MAXV = (64'd1 << DB) - 1;

    typedef struct {
        bit     v;
        int     ch;
        longint val;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic ce = 1'b0;

    always #5 clk = ~clk;

    lp_filter_mc_if #(.DATA_BITS(DB), .CH_W(CHW), .SHIFT_W(SHW)) bus ();
    lp_filter_mc_if #(.DATA_BITS(DB), .CH_W(2),   .SHIFT_W(SHW)) bus2 ();

    lp_filter_mc #(
        .DATA_BITS(DB), .CHANNELS(CH), .STAGE_COUNT(SC), .FRAC_BITS(FB), .SHIFT_W(SHW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ce(ce), .bus(bus.slave)
    );

    lp_filter_mc #(
        .DATA_BITS(DB), .CHANNELS(3), .STAGE_COUNT(0), .FRAC_BITS(FB), .SHIFT_W(SHW)
    ) dut2 (
        .clk(clk), .reset_n(reset_n), .ce(ce), .bus(bus2.slave)
    );

    int     tests_run = 0;
    int     tests_failed = 0;
    longint ym [CH][SC];
    bit     primed_m [CH];
    exp_t   exp_q [$];
    exp_t   last_exp;
    longint prev_obs;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: cascade of y += (x - y) >>> sh on the full-precision state.
    task automatic model_accept(input int ch, input longint val, input bit pr, input int sh,
                                output longint res);
        longint x;
        longint d;
        bit     p;
        p = pr || !primed_m[ch];
        primed_m[ch] = 1'b1;
        x = val << FB;
        for (int s = 0; s < SC; s++) begin
            if (p) begin
                ym[ch][s] = x;
            end else begin
                d = x - ym[ch][s];
                if (sh <= SW) ym[ch][s] = ym[ch][s] + (d >>> sh);
            end
            x = ym[ch][s];
        end
        res = (x + (64'd1 << (FB - 1))) >> FB;
        if (res > MAXV) res = MAXV;
    endtask

    task automatic sb_clear();
        exp_t b;
        b.v = 1'b0; b.ch = 0; b.val = 0;
        for (int c = 0; c < CH; c++) begin
            primed_m[c] = 1'b0;
            for (int s = 0; s < SC; s++) ym[c][s] = 0;
        end
        exp_q.delete();
        for (int i = 0; i < LAT - 1; i++) exp_q.push_back(b);
        last_exp = b;
        prev_obs = 0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        ce = 1'b1;
        bus.in_valid = 1'b0;
        bus2.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        sb_clear();
    endtask

    // One clock: drive inputs, advance the scoreboard, check the output register.
    task automatic cycle(input bit c_e, input bit v, input int ch, input longint val,
                         input bit pr, input int sh);
        exp_t e;
        ce = c_e;
        bus.in_valid   = v;
        bus.in_channel = CHW'(ch);
        bus.in_value   = DB'(val);
        bus.in_prime   = pr;
        bus.shift      = SHW'(sh);
        if (c_e) begin
            e.v = v && (ch < CH);
            e.ch = ch;
            e.val = 0;
            if (e.v) model_accept(ch, val, pr, sh, e.val);
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (c_e) last_exp = exp_q.pop_front();
        check("out_valid", bus.out_valid, last_exp.v);
        if (last_exp.v) begin
            check("out_channel", bus.out_channel, last_exp.ch);
            check("out_value", bus.out_value, last_exp.val);
        end
        if (!c_e) check("ce_frozen", bus.out_value, prev_obs);
        prev_obs = bus.out_value;
    endtask

    task automatic idle();
        cycle(1'b1, 1'b0, 0, 0, 1'b0, 4);
    endtask

    initial begin
        longint ilv [4];
        longint hist [$];
        longint prev;
        longint o;
        int     ch;
        longint val;

        ilv[0] = 1000; ilv[1] = 200000; ilv[2] = 0; ilv[3] = 5;
        bus.in_valid = 1'b0; bus.in_channel = '0; bus.in_value = '0;
        bus.in_prime = 1'b0; bus.shift = '0;
        bus2.in_valid = 1'b0; bus2.in_channel = '0; bus2.in_value = '0;
        bus2.in_prime = 1'b0; bus2.shift = '0;

        // Reset state
        do_reset();
        check("rst_valid", bus.out_valid, 0);
        check("rst_channel", bus.out_channel, 0);
        check("rst_value", bus.out_value, 0);
        check("rst2_valid", bus2.out_valid, 0);
        $display("[TB] reset state checked");

        // Priming and latency of 3
        cycle(1, 1, 0, 109377165, 0, 4);
        idle();
        idle();
        check("t1_prime_valid", bus.out_valid, 1);
        check("t1_prime_channel", bus.out_channel, 0);
        check("t1_prime_value", bus.out_value, 109377165);
        for (int i = 0; i < 5; i++) cycle(1, 1, 1, MAXV, 0, 4);
        idle();
        idle();
        check("t1_full_scale", bus.out_value, 268435455);
        $display("[TB] prime and full-scale sequence done");

        // Step down: non-increasing outputs settling onto the new level
        prev = 109377165;
        for (int i = 0; i < 600; i++) begin
            cycle(1, 1, 0, 54688582, 0, 4);
            if (bus.out_valid && bus.out_channel == 0) begin
                check("t2_monotone", (bus.out_value <= prev) ? 1 : 0, 1);
                prev = bus.out_value;
            end
        end
        idle();
        idle();
        o = bus.out_value;
        check("t2_settle_down", (o >= 54688581 && o <= 54688583) ? 1 : 0, 1);

        // Step back up with a 10-cycle clock-enable gap in the middle
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                for (int k = 0; k < 10; k++) cycle(0, 1, 0, 109377165, 0, 4);
            end
            cycle(1, 1, 0, 109377165, 0, 4);
        end
        idle();
        idle();
        o = bus.out_value;
        check("t2_settle_up", (o >= 109377164 && o <= 109377166) ? 1 : 0, 1);
        $display("[TB] step sequences with ce gap done");

        // Round-robin interleave, re-primed on the first pass
        for (int i = 0; i < 200; i++) begin
            cycle(1, 1, i % 4, ilv[i % 4], (i < 4) ? 1'b1 : 1'b0, 4);
            if (bus.out_valid) check("t3_own_const", bus.out_value, ilv[bus.out_channel]);
        end
        idle();
        idle();
        $display("[TB] interleave sequence done");

        // SHIFT=0: output is the input delayed by the latency
        hist.delete();
        for (int i = 0; i < 40; i++) begin
            ch = int'($urandom_range(0, 3));
            val = longint'($urandom_range(0, 32'h0FFF_FFFF));
            hist.push_back(val);
            cycle(1, 1, ch, val, 0, 0);
            if (i >= LAT - 1) check("t4_shift0", bus.out_value, hist[i - (LAT - 1)]);
        end
        idle();
        idle();
        cycle(1, 1, 2, 500000, 1, 4);
        for (int i = 0; i < 5; i++) cycle(1, 1, 2, 500000, 0, 4);
        cycle(1, 1, 2, 7, 1, 4);
        idle();
        idle();
        check("t4_reprime", bus.out_value, 7);
        $display("[TB] shift0 and re-prime done");

        // Pass-through instance: dropped out-of-range channel
        ce = 1'b1;
        bus2.in_valid = 1'b1; bus2.in_channel = 2'd1; bus2.in_value = 28'd77;
        @(posedge clk); #1;
        check("m_pass_valid", bus2.out_valid, 1);
        check("m_pass_channel", bus2.out_channel, 1);
        check("m_pass_value", bus2.out_value, 77);
        bus2.in_channel = 2'd3; bus2.in_value = 28'd99;
        @(posedge clk); #1;
        check("m_drop_valid", bus2.out_valid, 0);
        check("m_drop_hold", bus2.out_value, 77);
        bus2.in_channel = 2'd2; bus2.in_value = 28'd123456;
        @(posedge clk); #1;
        check("m_after_drop", bus2.out_value, 123456);
        bus2.in_valid = 1'b0;
        $display("[TB] pass-through and drop done");

        // Random run against the model
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 9) != 0), ($urandom_range(0, 4) != 0),
                  int'($urandom_range(0, 3)), longint'($urandom_range(0, 32'h0FFF_FFFF)),
                  ($urandom_range(0, 19) == 0), int'($urandom_range(0, 15)));
        end
        idle();
        idle();
        $display("[TB] random sequence done");

        // Asynchronous reset with two samples in flight
        for (int i = 0; i < 6; i++) cycle(1, 1, 0, 3000 + i, 0, 4);
        bus.in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("t6_async_valid", bus.out_valid, 0);
        check("t6_async_value", bus.out_value, 0);
        do_reset();
        for (int i = 0; i < 4; i++) idle();
        cycle(1, 1, 0, 42, 0, 4);
        idle();
        idle();
        check("t6_reprime_42", bus.out_value, 42);
        $display("[TB] mid-stream reset done");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
